word_addr_cache: RTL and testbench

- Direct-mapped, one-word-per-line, write-through, no-write-allocate cache between the CPU data port and the word-addressed data memory.
- The CPU side presents byte addresses. The memory side takes word addresses, equal to the byte address shifted right by two, which is the inverse of the branch-offset left shift.
- Each CPU access gets exactly one response pulse. Misses stall on a req/ack handshake to memory.

---
 rtl/word_addr_cache_pkg.sv | 26 ++
 rtl/word_addr_cache_array.sv | 45 ++++
 rtl/word_addr_cache.sv | 150 +++++++++++++++
 tb/tb_word_addr_cache.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/word_addr_cache_pkg.sv
// Shared types and address-split helpers for the word-addressed data cache.
package word_addr_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    MEM_WR,
    RESP
  } state_t;

  localparam int unsigned WORD_SHIFT = 2;

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned index_w);
    return (addr >> WORD_SHIFT) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned index_w);
    return addr >> (index_w + WORD_SHIFT);
  endfunction

  // Byte address to word address: inverse of the branch-offset left shift.
  function automatic logic [29:0] byte_to_word(input logic [31:0] addr);
    return addr[31:WORD_SHIFT];
  endfunction

endpackage

// File: rtl/word_addr_cache_array.sv
// Valid/tag/data storage: combinational read, single write port, synchronous clear-all of valid bits.
module word_addr_cache_array #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 26,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data contents are don't-care while invalid, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/word_addr_cache.sv
// Direct-mapped write-through, no-write-allocate cache with a req/ack memory port.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module word_addr_cache
  import word_addr_cache_pkg::*;
#(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [29:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned TAG_W = 32 - INDEX_W - WORD_SHIFT;

  state_t state, state_nx;

  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mis_q;

  logic [INDEX_W-1:0] in_index, q_index, wr_index;
  logic [TAG_W-1:0]   in_tag, q_tag, rd_tag, wr_tag;
  logic [DATA_W-1:0]  rd_data, wr_data;
  logic               rd_valid, wr_en, hit, misaligned, accept;

  assign in_index   = INDEX_W'(addr_index(addr_i, INDEX_W));
  assign in_tag     = TAG_W'(addr_tag(addr_i, INDEX_W));
  assign q_index    = INDEX_W'(addr_index(addr_q, INDEX_W));
  assign q_tag      = TAG_W'(addr_tag(addr_q, INDEX_W));
  assign hit        = rd_valid && (rd_tag == in_tag);
  assign misaligned = |addr_i[WORD_SHIFT-1:0];
  assign accept     = (state == IDLE) && req_i;

  word_addr_cache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk_i    (clk_i),
    .clr_i    (rst_i),
    .rd_index (in_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  // Store hits and fills share the one write port; a store hit rewrites the same tag.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    wr_index = in_index;
    wr_tag   = in_tag;
    wr_data  = wdata_i;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (misaligned) begin
            state_nx = RESP;
          end else if (we_i) begin
            wr_en    = hit;
            state_nx = MEM_WR;
          end else if (hit) begin
            state_nx = RESP;
          end else begin
            state_nx = MEM_RD;
          end
        end
      end
      MEM_RD: begin
        if (mem_ack_i) begin
          wr_en    = 1'b1;
          wr_index = q_index;
          wr_tag   = q_tag;
          wr_data  = mem_rdata_i;
          state_nx = RESP;
        end
      end
      MEM_WR: begin
        if (mem_ack_i) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        mis_q   <= misaligned;
        if (!we_i && !misaligned && hit) rdata_q <= rd_data;
      end
      if (state == MEM_RD && mem_ack_i) rdata_q <= mem_rdata_i;
    end
  end

  assign ready_o     = (state == RESP);
  assign misalign_o  = ready_o && mis_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = (state == MEM_RD) || (state == MEM_WR);
  assign mem_we_o    = (state == MEM_WR);
  assign mem_addr_o  = mem_req_o ? byte_to_word(addr_q) : '0;
  assign mem_wdata_o = mem_we_o ? wdata_q : '0;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (accept && !we_i && !misaligned) begin
      if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
      else     miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_word_addr_cache.sv
// Self-checking bench for word_addr_cache: vector table, response scoreboard, reset corner case.
module tb_word_addr_cache;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i, mem_ack_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic        ready_o, misalign_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_wdata_o;
  logic [29:0] mem_addr_o;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk = ~clk;

  word_addr_cache #(
    .INDEX_W (4),
    .DATA_W  (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ready_o     (ready_o),
    .rdata_o     (rdata_o),
    .misalign_o  (misalign_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_rd;
    logic        chk_rd;
    logic        exp_mem;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        chk_rd;
    logic        mis;
    logic        mem;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [logic [29:0]];
  vec_t        tbl [16];
  int          ack_delay = 0;
  int          checks = 0;
  int          errors = 0;
  int          hit_m = 0;
  int          miss_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ack after ack_delay extra cycles; ack_delay=0 acks in the first request cycle.
  initial begin
    int wait_cnt;
    wait_cnt    = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst_i || mem_ack_i) begin
        mem_ack_i = 1'b0;
        wait_cnt  = 0;
      end else if (mem_req_o) begin
        if (wait_cnt >= ack_delay) begin
          if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
          mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'hBAD0_0000;
          mem_ack_i   = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input string name);
    exp_t        e;
    int          lat;
    logic        saw_mem, addr_ok, got;
    ack_delay = v.delay;
    e.rd = v.exp_rd; e.chk_rd = v.chk_rd; e.mis = v.exp_mis; e.mem = v.exp_mem;
    sb.push_back(e);
    @(negedge clk);
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; addr_i = $urandom; wdata_i = $urandom;
    lat = 1; saw_mem = 1'b0; addr_ok = 1'b1; got = 1'b0;
    while (!got && lat <= 40) begin
      if (mem_req_o) begin
        saw_mem = 1'b1;
        if (mem_addr_o !== v.addr[31:2] || mem_we_o !== v.we || (v.we && mem_wdata_o !== v.wdata))
          addr_ok = 1'b0;
      end
      if (ready_o) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no ready_o expected ready_o within 40 cycles", name);
      return;
    end
    check({name, " misalign"}, {31'd0, misalign_o}, {31'd0, e.mis});
    if (e.chk_rd) check({name, " rdata"}, rdata_o, e.rd);
    check({name, " mem_access"}, {31'd0, saw_mem}, {31'd0, e.mem});
    if (e.mem) check({name, " mem_port"}, {31'd0, addr_ok}, 32'd1);
    else       check({name, " latency"}, lat, 32'd1);
    @(negedge clk);
    check({name, " ready_width"}, {31'd0, ready_o}, 32'd0);
    if (!v.we && !v.exp_mis) begin
      if (v.exp_mem) miss_m++;
      else           hit_m++;
    end
  endtask

  initial begin
    logic saw_ready;
    tbl[0]  = '{1'b0, 32'h0000_0040, 32'h0,         3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0040, 32'h0,         0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0080, 32'h0,         0, 32'h8080_8080, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 32'h0000_0040, 32'h0,         1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 2, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0040, 32'h0,         0, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 0, 32'h1234_5678, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0100, 32'h0,         2, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_0040, 32'h0,         0, 32'h1234_5678, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0042, 32'h0,         0, 32'h0,         1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 32'h0000_0047, 32'hFFFF_FFFF, 0, 32'h0,         1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 32'h0000_0044, 32'h0,         1, 32'h1111_2222, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0044, 32'h0,         0, 32'h1111_2222, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h0000_003C, 32'h0,         0, 32'hF0F0_F0F0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 32'h0000_003C, 32'h0,         0, 32'hF0F0_F0F0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 32'h0000_0040, 32'h0,         0, 32'h1234_5678, 1'b1, 1'b0, 1'b0};

    mem_model[30'h10] = 32'hDEAD_BEEF;
    mem_model[30'h20] = 32'h8080_8080;
    mem_model[30'h11] = 32'h1111_2222;
    mem_model[30'h0F] = 32'hF0F0_F0F0;

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    check("reset ready_o",     {31'd0, ready_o},    32'd0);
    check("reset misalign_o",  {31'd0, misalign_o}, 32'd0);
    check("reset rdata_o",     rdata_o,             32'd0);
    check("reset mem_req_o",   {31'd0, mem_req_o},  32'd0);
    check("reset mem_we_o",    {31'd0, mem_we_o},   32'd0);
    check("reset mem_addr_o",  {2'b0, mem_addr_o},  32'd0);
    check("reset mem_wdata_o", mem_wdata_o,         32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while a fill is outstanding: no response, no memory request, cache emptied.
    ack_delay = 100;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0200;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    check("midrst mem_req_before", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("midrst mem_req_after", {31'd0, mem_req_o}, 32'd0);
    check("midrst rdata_o",       rdata_o,            32'd0);
    saw_ready = ready_o;
    repeat (4) begin
      @(negedge clk);
      if (ready_o) saw_ready = 1'b1;
    end
    check("midrst no_ready", {31'd0, saw_ready}, 32'd0);
`ifdef CACHE_STATS_EN
    check("midrst hit_cnt",  hit_cnt_o,  32'd0);
    check("midrst miss_cnt", miss_cnt_o, 32'd0);
`endif
    hit_m = 0; miss_m = 0;
    run_vec('{1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678, 1'b1, 1'b1, 1'b0}, "post_rst_miss");
    run_vec('{1'b0, 32'h0000_0040, 32'h0, 0, 32'h1234_5678, 1'b1, 1'b0, 1'b0}, "post_rst_hit");

`ifdef CACHE_STATS_EN
    check("final hit_cnt",  hit_cnt_o,  hit_m);
    check("final miss_cnt", miss_cnt_o, miss_m);
`endif
    check("scoreboard empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
